// File: rtl/stack_ctrl_mc.sv
// Multicycle control FSM for the stack CPU: decodes the opcode, sequences the datapath strobes,
// and tracks stack occupancy so that overflow, underflow and illegal opcodes stop in a sticky FAULT state.
//
// state | meaning
// IF    | fetch instruction, advance PC (waits on mem_ready)
// ID    | decode, stack-depth check, branch
// RTYPE | pop first operand (binary ops)
// SP    | pop second operand into B
// NOT1  | pop single operand (NOT)
// ALU   | compute into B
// SAVE  | push result
// PUSH  | memory read pushed onto stack (waits on mem_ready)
// POP   | stack top written to memory (waits on mem_ready)
// JUMP  | unconditional jump
// JZ    | jump if zero flag set
// HALT  | terminal, halted=1
// FAULT | terminal, fault=1
module stack_ctrl_mc #(
  parameter int OPW    = 4,
  parameter int DEPTH  = 16,
  parameter int MEM_HS = 1,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           next,
  output logic           jump,
  output logic           PCL,
  output logic           LorD,
  output logic           MR,
  output logic           MW,
  output logic           LR,
  output logic           StackSrc,
  output logic           RegDst,
  output logic           ToS,
  output logic           Push,
  output logic           Pop,
  output logic           LA,
  output logic           LB,
  output logic           Ain,
  output logic           Bin,
  output logic [1:0]     ALUop,
  output logic [SPW-1:0] sp_count,
  output logic           halted,
  output logic           fault
);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_RTYPE, S_SP, S_NOT1, S_ALU, S_SAVE,
    S_PUSH, S_POP, S_JUMP, S_JZ, S_HALT, S_FAULT
  } state_t;

  localparam logic [SPW-1:0] DEPTH_C = SPW'(DEPTH);

  state_t state, state_nxt;

  logic [OPW-4:0] ext;
  logic [2:0]     base;
  logic           is_base, is_halt, is_nop, depth_ok, mem_ok;

  assign ext     = opcode[OPW-1:3];
  assign base    = opcode[2:0];
  assign is_base = (ext == '0);
  assign is_halt = (&ext) && (base == 3'b111);
  assign is_nop  = (&ext) && (base == 3'b000);
  assign mem_ok  = (MEM_HS == 0) || mem_ready;

  always_comb begin
    depth_ok = 1'b1;
    if (is_base) begin
      case (base)
        3'b000, 3'b001, 3'b010: depth_ok = (sp_count >= SPW'(2));
        3'b011, 3'b101:         depth_ok = (sp_count >= SPW'(1));
        3'b100:                 depth_ok = (sp_count < DEPTH_C);
        default:                depth_ok = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= state_nxt;
  end

  // Strobes are forced low while rst is high, since the reset state (IF) would otherwise drive them.
  always_comb begin
    state_nxt = state;
    next = 1'b0; jump = 1'b0; PCL = 1'b0; LorD = 1'b0; MR = 1'b0; MW = 1'b0;
    LR = 1'b0; StackSrc = 1'b0; RegDst = 1'b0; ToS = 1'b0; Push = 1'b0; Pop = 1'b0;
    LA = 1'b0; LB = 1'b0; Ain = 1'b0; Bin = 1'b0; ALUop = 2'b00;
    halted = 1'b0; fault = 1'b0;
    if (!rst) begin
      case (state)
        S_IF: begin
          next = 1'b1; PCL = 1'b1; LorD = 1'b1; MR = 1'b1; LR = 1'b1; Ain = 1'b1;
          if (mem_ok) state_nxt = S_ID;
        end
        S_ID: begin
          ToS = 1'b1; LA = 1'b1;
          if (!(is_base || is_halt || is_nop) || !depth_ok) state_nxt = S_FAULT;
          else if (is_halt) state_nxt = S_HALT;
          else if (is_nop)  state_nxt = S_IF;
          else begin
            case (base)
              3'b011:  state_nxt = S_NOT1;
              3'b100:  state_nxt = S_PUSH;
              3'b101:  state_nxt = S_POP;
              3'b110:  state_nxt = S_JUMP;
              3'b111:  state_nxt = S_JZ;
              default: state_nxt = S_RTYPE;
            endcase
          end
        end
        S_RTYPE: begin
          Pop = 1'b1; ALUop = 2'b11;
          state_nxt = S_SP;
        end
        S_SP: begin
          Pop = 1'b1; ToS = 1'b1; RegDst = 1'b1; LB = 1'b1;
          state_nxt = S_ALU;
        end
        S_NOT1: begin
          Pop = 1'b1;
          state_nxt = S_ALU;
        end
        S_ALU: begin
          Bin = 1'b1; ALUop = opcode[1:0];
          state_nxt = S_SAVE;
        end
        S_SAVE: begin
          StackSrc = 1'b1; Push = 1'b1;
          state_nxt = S_IF;
        end
        S_PUSH: begin
          MR = 1'b1;
          if (mem_ok) begin
            Push = 1'b1;
            state_nxt = S_IF;
          end
        end
        S_POP: begin
          MW = 1'b1;
          if (mem_ok) begin
            Pop = 1'b1;
            state_nxt = S_IF;
          end
        end
        S_JUMP: begin
          jump = 1'b1; PCL = 1'b1;
          state_nxt = S_IF;
        end
        S_JZ: begin
          jump = zero; PCL = zero;
          state_nxt = S_IF;
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault = 1'b1;
        default: state_nxt = S_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sp_count <= '0;
    else if (Push) sp_count <= sp_count + SPW'(1);
    else if (Pop)  sp_count <= sp_count - SPW'(1);
  end

endmodule

// File: tb/tb_stack_ctrl_mc.sv
// Scoreboard bench for stack_ctrl_mc: stimulus queues the expected per-cycle outputs,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_stack_ctrl_mc;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero, mem_ready;
  logic       next, jump, PCL, LorD, MR, MW, LR, StackSrc, RegDst, ToS, Push, Pop, LA, LB, Ain, Bin;
  logic [1:0] ALUop;
  logic [2:0] sp_count;
  logic       halted, fault;

  stack_ctrl_mc #(.OPW(4), .DEPTH(DEPTH), .MEM_HS(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .next(next), .jump(jump), .PCL(PCL), .LorD(LorD), .MR(MR), .MW(MW), .LR(LR),
    .StackSrc(StackSrc), .RegDst(RegDst), .ToS(ToS), .Push(Push), .Pop(Pop),
    .LA(LA), .LB(LB), .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .sp_count(sp_count),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // strobe vector order: next jump PCL LorD MR MW LR StackSrc RegDst ToS Push Pop LA LB Ain Bin
  localparam logic [15:0] V_IF    = 16'hBA02;
  localparam logic [15:0] V_ID    = 16'h0048;
  localparam logic [15:0] V_RTYPE = 16'h0010;
  localparam logic [15:0] V_SP    = 16'h00D4;
  localparam logic [15:0] V_NOT1  = 16'h0010;
  localparam logic [15:0] V_ALU   = 16'h0001;
  localparam logic [15:0] V_SAVE  = 16'h0120;
  localparam logic [15:0] V_PUSHW = 16'h0800;
  localparam logic [15:0] V_PUSHX = 16'h0820;
  localparam logic [15:0] V_POPW  = 16'h0400;
  localparam logic [15:0] V_POPX  = 16'h0410;
  localparam logic [15:0] V_JMP   = 16'h6000;
  localparam logic [15:0] V_NONE  = 16'h0000;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_NOT = 4'b0011, OP_PUSH = 4'b0100,
                         OP_POP = 4'b0101, OP_JUMP = 4'b0110, OP_JZ = 4'b0111, OP_NOP = 4'b1000,
                         OP_ILL = 4'b1010, OP_HALT = 4'b1111;

  typedef struct {
    string       nm;
    logic [15:0] v;
    logic [1:0]  a;
    logic [2:0]  sp;
    logic        h;
    logic        f;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] got;
      e = q.pop_front();
      got = {next, jump, PCL, LorD, MR, MW, LR, StackSrc, RegDst, ToS, Push, Pop, LA, LB, Ain, Bin};
      n_cmp++;
      if (got !== e.v || ALUop !== e.a || sp_count !== e.sp || halted !== e.h || fault !== e.f) begin
        n_bad++;
        $display("FAIL %s: strobes=%h aluop=%b sp=%0d halted=%b fault=%b, required strobes=%h aluop=%b sp=%0d halted=%b fault=%b",
                 e.nm, got, ALUop, sp_count, halted, fault, e.v, e.a, e.sp, e.h, e.f);
      end
    end
  end

  task automatic cyc(input string nm, input logic [15:0] v, input logic [1:0] a,
                     input int sp, input logic h, input logic f);
    exp_t e;
    e.nm = nm; e.v = v; e.a = a; e.sp = 3'(sp); e.h = h; e.f = f;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [3:0] op, input int sp);
    opcode = op;
    cyc("if", V_IF, 2'b00, sp, 1'b0, 1'b0);
    cyc("id", V_ID, 2'b00, sp, 1'b0, 1'b0);
  endtask

  task automatic do_push(input int sp);
    fetch(OP_PUSH, sp);
    cyc("push_exit", V_PUSHX, 2'b00, sp, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc("in_reset", V_NONE, 2'b00, 0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = OP_PUSH; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // ADD at depth 2
    do_push(0);
    do_push(1);
    fetch(OP_ADD, 2);
    cyc("add_rtype", V_RTYPE, 2'b11, 2, 1'b0, 1'b0);
    cyc("add_sp",    V_SP,    2'b00, 1, 1'b0, 1'b0);
    cyc("add_alu",   V_ALU,   2'b00, 0, 1'b0, 1'b0);
    cyc("add_save",  V_SAVE,  2'b00, 0, 1'b0, 1'b0);

    // PUSH with three memory wait cycles
    fetch(OP_PUSH, 1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("push_wait", V_PUSHW, 2'b00, 1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cyc("push_exit_w", V_PUSHX, 2'b00, 1, 1'b0, 1'b0);

    // SUB with one fetch wait cycle
    opcode = OP_SUB; mem_ready = 1'b0;
    cyc("if_wait", V_IF, 2'b00, 2, 1'b0, 1'b0);
    mem_ready = 1'b1;
    fetch(OP_SUB, 2);
    cyc("sub_rtype", V_RTYPE, 2'b11, 2, 1'b0, 1'b0);
    cyc("sub_sp",    V_SP,    2'b00, 1, 1'b0, 1'b0);
    cyc("sub_alu",   V_ALU,   2'b01, 0, 1'b0, 1'b0);
    cyc("sub_save",  V_SAVE,  2'b00, 0, 1'b0, 1'b0);

    fetch(OP_NOT, 1);
    cyc("not1",     V_NOT1, 2'b00, 1, 1'b0, 1'b0);
    cyc("not_alu",  V_ALU,  2'b11, 0, 1'b0, 1'b0);
    cyc("not_save", V_SAVE, 2'b00, 0, 1'b0, 1'b0);

    zero = 1'b1;
    fetch(OP_JZ, 1);
    cyc("jz_taken", V_JMP, 2'b00, 1, 1'b0, 1'b0);
    zero = 1'b0;
    fetch(OP_JZ, 1);
    cyc("jz_not_taken", V_NONE, 2'b00, 1, 1'b0, 1'b0);
    fetch(OP_JUMP, 1);
    cyc("jump", V_JMP, 2'b00, 1, 1'b0, 1'b0);

    // NOP goes straight back to IF, then POP with one wait
    fetch(OP_NOP, 1);
    fetch(OP_POP, 1);
    mem_ready = 1'b0;
    cyc("pop_wait", V_POPW, 2'b00, 1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cyc("pop_exit", V_POPX, 2'b00, 1, 1'b0, 1'b0);

    fetch(OP_POP, 0);
    cyc("underflow_fault", V_NONE, 2'b00, 0, 1'b0, 1'b1);
    cyc("fault_sticky",    V_NONE, 2'b00, 0, 1'b0, 1'b1);
    do_reset();

    fetch(OP_ILL, 0);
    cyc("illegal_fault", V_NONE, 2'b00, 0, 1'b0, 1'b1);
    do_reset();

    fetch(OP_HALT, 0);
    cyc("halt",        V_NONE, 2'b00, 0, 1'b1, 1'b0);
    cyc("halt_sticky", V_NONE, 2'b00, 0, 1'b1, 1'b0);
    do_reset();

    // overflow at DEPTH
    for (int i = 0; i < DEPTH; i++) do_push(i);
    fetch(OP_PUSH, DEPTH);
    for (int i = 0; i < 3; i++) cyc("overflow_fault", V_NONE, 2'b00, DEPTH, 1'b0, 1'b1);
    do_reset();

    // reset in the middle of an ADD's ALU cycle
    do_push(0);
    do_push(1);
    fetch(OP_ADD, 2);
    cyc("r_rtype", V_RTYPE, 2'b11, 2, 1'b0, 1'b0);
    cyc("r_sp",    V_SP,    2'b00, 1, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("rst_in_alu", V_NONE, 2'b00, 0, 1'b0, 1'b0);
    rst = 1'b0;
    fetch(OP_JUMP, 0);
    cyc("jump_after_rst", V_JMP, 2'b00, 0, 1'b0, 1'b0);

    @(negedge clk); #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
